sonar_scheduler: RTL and testbench
==================================

// Module: sonar_scheduler
// PURPOSE
//  Round-robin sequencer for CHANNELS ultrasonic rangefinders sharing one echo-width measurer (PulseMeasure).
//  Per channel: fire trigger, wait for echo, route that echo into the measurer, store the width or a timeout.
//  Then insert a settle gap and advance to the next channel.
//  Sits between the sonar pins and the register/bus layer that reads per-channel ranges.
// PARAMETERS
//  CHANNELS        4          number of sonar channels (>=2)
//  TRIG_CYCLES     500        trigger pulse width, clk cycles (10 us @ 50 MHz)
//  PREDIV          50         measurer prescale, clk cycles per count tick
//  MAXV            32768      measurer saturation range; CNT_W = $clog2(MAXV)
//  TIMEOUT_CYCLES  1500000    max cycles from trigger end to echo end before the channel is abandoned
//  GAP_CYCLES      50000      settle time after each channel, before the next trigger
// PORTS
//  clk             in   1        system clock
//  reset           in   1        synchronous, active-high reset
//  enable          in   1        run scanning while high
//  echo_in         in   CHANNELS raw asynchronous echo pins
//  trig_out        out  CHANNELS trigger pins; at most one bit high at a time
//  busy            out  1        high in any state other than IDLE
//  cur_ch          out  CH_W     channel currently being serviced; CH_W = max(1,$clog2(CHANNELS))
//  result_stb      out  1        one-cycle pulse when a channel result is written
//  result_ch       out  CH_W     channel of the result; valid with result_stb
//  result_value    out  CNT_W    echo width in ticks, MAXV-1 on timeout; valid with result_stb
//  result_timeout  out  1        result was a timeout; valid with result_stb
//  scan_done       out  1        one-cycle pulse after the result of channel CHANNELS-1
//  rd_sel          in   CH_W     combinational read address
//  rd_value        out  CNT_W    stored width for rd_sel
//  rd_flags        out  2        {valid, timeout} for rd_sel
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM IDLE; cur_ch=0; result file value=0 and flags=0; synchronizers 0.
//  - Echo sync: each echo_in bit passes through a 2-flop synchronizer. All echo logic uses the synced value.
//  - FSM states and transitions:
//    IDLE -> TRIG when enable.
//    TRIG: trig_out[cur_ch]=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO. The timeout counter clears on TRIG exit.
//    WAIT_ECHO: only a rising edge (prev 0, now 1) of synced echo[cur_ch] arms the channel and enters MEASURE.
//      An echo already high on entry is ignored until it falls and rises again.
//    MEASURE: wait for the measurer strobe, then go to STORE.
//    STORE: write the result, pulse result_stb, go to GAP.
//    Timeout in WAIT_ECHO or MEASURE: counter reaches TIMEOUT_CYCLES-1 -> write value=MAXV-1, timeout=1, then GAP.
//    GAP: hold for GAP_CYCLES; cur_ch advances (wraps CHANNELS-1 -> 0); go to TRIG if enable, else IDLE.
//  - Measurer input = synced echo[cur_ch] AND armed. armed clears on entry to STORE, timeout, and reset.
//  - A strobe from the measurer outside MEASURE is ignored; this covers the gating edge on timeout or reset.
//  - Width result = measurer output: ticks of PREDIV cycles, saturating at MAXV-1, not flagged as timeout.
//  - Latency: synced echo fall -> measurer strobe +1 cycle -> result_stb, file write and outputs on the following edge.
//  - enable is sampled only in IDLE and at GAP exit. Dropping it mid-channel completes that channel.
//  - scan_done is coincident with the result_stb of channel CHANNELS-1, including timeouts.
//  - Reset mid-operation: on the next edge trig_out=0, FSM IDLE, file cleared, no result_stb.
//    The measurer has no reset; its stale strobe is discarded because FSM is not in MEASURE.
//  - The result file is one entry per channel, overwritten on each visit; rd_* is a combinational read.
//    An rd_sel >= CHANNELS returns 0.
// STRUCTURE
//  - Shared header sonar_pkg.vh holds: FSM state encoding (IDLE, TRIG, WAIT_ECHO, MEASURE, STORE, GAP),
//    CH_W/CNT_W macros, and the flag bit positions.
//  - Sub-module: one PulseMeasure #(PREDIV, MAXV) instance as the shared echo measurer.
//  - A single down-counter reloads for TRIG, timeout and GAP; it is sized for the largest of the three.
// TESTING (params: CHANNELS=2, TRIG_CYCLES=4, PREDIV=2, MAXV=64, TIMEOUT_CYCLES=200, GAP_CYCLES=8)
//  1. Hold reset 3 cycles, enable=1 -> all outputs 0 during reset; trig_out=01 for exactly 4 cycles after release.
//  2. ch0 echo rises 10 cycles after trigger end, high 20 cycles ->
//     result_stb with ch=0, value=10+/-1, timeout=0; rd_sel=0 gives flags=10; then trig_out=10 after the 8-cycle gap.
//  3. No echo on ch1 -> 200 cycles after trigger end: result_stb, ch=1, value=63, timeout=1, scan_done=1, cur_ch wraps to 0.
//  4. ch0 echo high 150 cycles -> value=63 (saturated), timeout=0.
//  5. ch1 echo stuck high from before its trigger -> no arm; timeout result 63/1.
//     Also: drop enable during a MEASURE -> that channel completes, then IDLE, busy=0.
//  6. Assert reset mid-MEASURE with echo high -> next edge trig_out=0, busy=0, rd_flags=00; no result_stb afterwards.

Source files
------------

// File: rtl/sonar_scheduler_pkg.sv
// Shared types and helpers for the sonar channel scheduler.
package sonar_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    STORE,
    GAP
  } state_t;

  // Bit positions inside rd_flags / result file flags
  localparam int FLAG_VALID   = 1;
  localparam int FLAG_TIMEOUT = 0;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sonar_scheduler_pulse_measure.sv
// Echo width measurer: counts PREDIV-cycle ticks while pulse is high, saturating
// at MAXV-1, and strobes the width one cycle after the falling edge. No reset.
module sonar_scheduler_pulse_measure #(
  parameter int PREDIV = 50,
  parameter int MAXV   = 32768,
  localparam int CNT_W = $clog2(MAXV),
  localparam int PRE_W = (PREDIV > 1) ? $clog2(PREDIV) : 1
) (
  input  logic             clk,
  input  logic             pulse,
  output logic             strobe,
  output logic [CNT_W-1:0] width
);

  logic             prev;
  logic [PRE_W-1:0] pre, pre_base;
  logic [CNT_W-1:0] cnt, cnt_base;
  logic             rise, fall;

  assign rise = pulse & ~prev;
  assign fall = prev & ~pulse;

  // A new pulse restarts both counters from zero in its first high cycle
  always_comb begin
    pre_base = rise ? '0 : pre;
    cnt_base = rise ? '0 : cnt;
  end

  always_ff @(posedge clk) begin
    prev   <= pulse;
    strobe <= fall;
    if (fall) width <= cnt;
    if (pulse) begin
      if (pre_base == PRE_W'(PREDIV - 1)) begin
        pre <= '0;
        cnt <= (cnt_base == CNT_W'(MAXV - 1)) ? cnt_base : cnt_base + 1'b1;
      end else begin
        pre <= pre_base + 1'b1;
        cnt <= cnt_base;
      end
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo sequencer for CHANNELS sonars sharing one width
// measurer, with a per-channel result file readable combinationally.
module sonar_scheduler
  import sonar_scheduler_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int PREDIV         = 50,
  parameter int MAXV           = 32768,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 50000,
  localparam int CH_W  = ch_width(CHANNELS),
  localparam int CNT_W = $clog2(MAXV)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] echo_in,
  output logic [CHANNELS-1:0] trig_out,
  output logic                busy,
  output logic [CH_W-1:0]     cur_ch,
  output logic                result_stb,
  output logic [CH_W-1:0]     result_ch,
  output logic [CNT_W-1:0]    result_value,
  output logic                result_timeout,
  output logic                scan_done,
  input  logic [CH_W-1:0]     rd_sel,
  output logic [CNT_W-1:0]    rd_value,
  output logic [1:0]          rd_flags
);

  localparam int CTR_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES));

  state_t              state, state_n;
  logic [CHANNELS-1:0] sync1, sync2, echo_prev;
  logic [CTR_W-1:0]    ctr, ctr_val;
  logic                ctr_load;
  logic                armed, arm_set, arm_clr;
  logic                res_load, res_to;
  logic [CNT_W-1:0]    res_val;
  logic                ch_adv, last_ch;
  logic                echo_cur, echo_rise, meas_in, meas_stb;
  logic [CNT_W-1:0]    meas_width;
  logic [CNT_W-1:0]    file_value [CHANNELS];
  logic [1:0]          file_flags [CHANNELS];

  assign echo_cur  = sync2[cur_ch];
  assign echo_rise = echo_cur & ~echo_prev[cur_ch];
  assign meas_in   = echo_cur & armed;
  assign last_ch   = (cur_ch == CH_W'(CHANNELS - 1));

  assign busy       = (state != IDLE);
  assign result_stb = (state == STORE);
  assign result_ch  = cur_ch;
  assign scan_done  = result_stb & last_ch;

  always_comb begin
    trig_out = '0;
    if (state == TRIG) trig_out[cur_ch] = 1'b1;
  end

  sonar_scheduler_pulse_measure #(.PREDIV(PREDIV), .MAXV(MAXV)) u_measure (
    .clk   (clk),
    .pulse (meas_in),
    .strobe(meas_stb),
    .width (meas_width)
  );

  always_comb begin
    state_n  = state;
    ctr_load = 1'b0;
    ctr_val  = '0;
    arm_set  = 1'b0;
    arm_clr  = 1'b0;
    res_load = 1'b0;
    res_val  = '0;
    res_to   = 1'b0;
    ch_adv   = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_n  = TRIG;
        ctr_load = 1'b1;
        ctr_val  = CTR_W'(TRIG_CYCLES - 1);
      end
      TRIG: if (ctr == '0) begin
        state_n  = WAIT_ECHO;
        ctr_load = 1'b1;
        ctr_val  = CTR_W'(TIMEOUT_CYCLES - 1);
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_n = MEASURE;
          arm_set = 1'b1;
        end else if (ctr == '0) begin
          state_n  = STORE;
          arm_clr  = 1'b1;
          res_load = 1'b1;
          res_val  = CNT_W'(MAXV - 1);
          res_to   = 1'b1;
        end
      end
      // A real width wins over a timeout landing on the same cycle
      MEASURE: begin
        if (meas_stb) begin
          state_n  = STORE;
          arm_clr  = 1'b1;
          res_load = 1'b1;
          res_val  = meas_width;
        end else if (ctr == '0) begin
          state_n  = STORE;
          arm_clr  = 1'b1;
          res_load = 1'b1;
          res_val  = CNT_W'(MAXV - 1);
          res_to   = 1'b1;
        end
      end
      STORE: begin
        state_n  = GAP;
        ctr_load = 1'b1;
        ctr_val  = CTR_W'(GAP_CYCLES - 1);
      end
      GAP: if (ctr == '0) begin
        ch_adv = 1'b1;
        if (enable) begin
          state_n  = TRIG;
          ctr_load = 1'b1;
          ctr_val  = CTR_W'(TRIG_CYCLES - 1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sync1          <= '0;
      sync2          <= '0;
      echo_prev      <= '0;
      ctr            <= '0;
      armed          <= 1'b0;
      cur_ch         <= '0;
      result_value   <= '0;
      result_timeout <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        file_value[i] <= '0;
        file_flags[i] <= '0;
      end
    end else begin
      state     <= state_n;
      sync1     <= echo_in;
      sync2     <= sync1;
      echo_prev <= sync2;
      if (ctr_load) ctr <= ctr_val;
      else if (ctr != '0) ctr <= ctr - 1'b1;
      if (arm_clr) armed <= 1'b0;
      else if (arm_set) armed <= 1'b1;
      if (res_load) begin
        result_value   <= res_val;
        result_timeout <= res_to;
      end
      if (ch_adv) cur_ch <= last_ch ? '0 : cur_ch + 1'b1;
      if (state == STORE) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (cur_ch == CH_W'(i)) begin
            file_value[i]               <= result_value;
            file_flags[i][FLAG_VALID]   <= 1'b1;
            file_flags[i][FLAG_TIMEOUT] <= result_timeout;
          end
        end
      end
    end
  end

  // Addresses with no matching channel read as zero
  always_comb begin
    rd_value = '0;
    rd_flags = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == CH_W'(i)) begin
        rd_value = file_value[i];
        rd_flags = file_flags[i];
      end
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with small parameters (2 channels, short timings).
module tb_sonar_scheduler;

  localparam int CHANNELS = 2;
  localparam int CH_W     = 1;
  localparam int CNT_W    = 6;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [CHANNELS-1:0] echo_in = '0;
  logic [CHANNELS-1:0] trig_out;
  logic                busy;
  logic [CH_W-1:0]     cur_ch;
  logic                result_stb;
  logic [CH_W-1:0]     result_ch;
  logic [CNT_W-1:0]    result_value;
  logic                result_timeout;
  logic                scan_done;
  logic [CH_W-1:0]     rd_sel = '0;
  logic [CNT_W-1:0]    rd_value;
  logic [1:0]          rd_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .CHANNELS(2), .TRIG_CYCLES(4), .PREDIV(2), .MAXV(64),
    .TIMEOUT_CYCLES(200), .GAP_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo_in(echo_in),
    .trig_out(trig_out), .busy(busy), .cur_ch(cur_ch),
    .result_stb(result_stb), .result_ch(result_ch), .result_value(result_value),
    .result_timeout(result_timeout), .scan_done(scan_done),
    .rd_sel(rd_sel), .rd_value(rd_value), .rd_flags(rd_flags)
  );

  // Returns the number of sampled cycles a trigger stays high; ends on the first cycle after it.
  task automatic wait_trig_end(output int len);
    int w;
    w = 0;
    len = 0;
    while (trig_out == '0 && w < 50) begin @(negedge clk); w++; end
    while (trig_out != '0 && len < 50) begin len++; @(negedge clk); end
  endtask

  task automatic wait_stb(input int bound, output int n);
    n = 0;
    while (!result_stb && n < bound) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    int len;
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({trig_out, busy, cur_ch, result_stb, scan_done, rd_flags, rd_value, result_value} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d: trig=%b busy=%b ch=%b stb=%b done=%b flags=%b rdv=%0d resv=%0d, want all 0",
                 i, trig_out, busy, cur_ch, result_stb, scan_done, rd_flags, rd_value, result_value);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (trig_out !== 2'b01) begin
      failures++;
      $display("FAIL first_trig: trig_out=%b want 01", trig_out);
    end
    wait_trig_end(len);
    checks++;
    if (len != 4) begin
      failures++;
      $display("FAIL trig_width: got %0d cycles want 4", len);
    end
  endtask

  task automatic test_ch0_echo;
    int n, g;
    logic [CNT_W-1:0] v;
    repeat (10) @(negedge clk);
    echo_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    echo_in[0] = 1'b0;
    wait_stb(100, n);
    checks++;
    if (result_stb !== 1'b1 || result_ch !== 1'b0 || result_timeout !== 1'b0 || scan_done !== 1'b0) begin
      failures++;
      $display("FAIL ch0_result: stb=%b ch=%b to=%b done=%b want 1/0/0/0", result_stb, result_ch, result_timeout, scan_done);
    end
    checks++;
    if (result_value < 9 || result_value > 11) begin
      failures++;
      $display("FAIL ch0_width: got %0d want 9..11", result_value);
    end
    v = result_value;
    rd_sel = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_flags !== 2'b10 || rd_value !== v) begin
      failures++;
      $display("FAIL ch0_readback: flags=%b value=%0d want 10/%0d", rd_flags, rd_value, v);
    end
    g = 1;
    while (trig_out == '0 && g < 40) begin @(negedge clk); g++; end
    checks++;
    if (trig_out !== 2'b10 || g != 9 || cur_ch !== 1'b1) begin
      failures++;
      $display("FAIL ch1_trig_after_gap: trig=%b after %0d cycles ch=%b want 10 after 9 ch=1", trig_out, g, cur_ch);
    end
  endtask

  task automatic test_timeout;
    int len, n;
    wait_trig_end(len);
    wait_stb(400, n);
    checks++;
    if (result_stb !== 1'b1 || n != 200) begin
      failures++;
      $display("FAIL timeout_latency: stb=%b after %0d cycles want 1 after 200", result_stb, n);
    end
    checks++;
    if (result_ch !== 1'b1 || result_value !== 6'd63 || result_timeout !== 1'b1 || scan_done !== 1'b1) begin
      failures++;
      $display("FAIL timeout_result: ch=%b v=%0d to=%b done=%b want 1/63/1/1", result_ch, result_value, result_timeout, scan_done);
    end
    rd_sel = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_flags !== 2'b11 || rd_value !== 6'd63) begin
      failures++;
      $display("FAIL timeout_readback: flags=%b value=%0d want 11/63", rd_flags, rd_value);
    end
    n = 0;
    while (trig_out == '0 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (trig_out !== 2'b01 || cur_ch !== 1'b0) begin
      failures++;
      $display("FAIL wrap: trig=%b ch=%b want 01/0", trig_out, cur_ch);
    end
  endtask

  task automatic test_saturate;
    int len, n;
    wait_trig_end(len);
    repeat (3) @(negedge clk);
    echo_in[0] = 1'b1;
    repeat (150) @(negedge clk);
    echo_in[0] = 1'b0;
    wait_stb(100, n);
    checks++;
    if (result_stb !== 1'b1 || result_ch !== 1'b0 || result_value !== 6'd63 || result_timeout !== 1'b0) begin
      failures++;
      $display("FAIL saturate: stb=%b ch=%b v=%0d to=%b want 1/0/63/0", result_stb, result_ch, result_value, result_timeout);
    end
  endtask

  task automatic test_stuck_echo;
    int len, n;
    @(negedge clk);
    echo_in[1] = 1'b1;
    wait_trig_end(len);
    wait_stb(400, n);
    checks++;
    if (result_stb !== 1'b1 || n != 200 || result_ch !== 1'b1 || result_value !== 6'd63 ||
        result_timeout !== 1'b1 || scan_done !== 1'b1) begin
      failures++;
      $display("FAIL stuck_echo: stb=%b n=%0d ch=%b v=%0d to=%b done=%b want 1/200/1/63/1/1",
               result_stb, n, result_ch, result_value, result_timeout, scan_done);
    end
    echo_in[1] = 1'b0;
  endtask

  task automatic test_enable_drop;
    int len, n, b;
    wait_trig_end(len);
    repeat (3) @(negedge clk);
    echo_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    echo_in[0] = 1'b0;
    wait_stb(100, n);
    checks++;
    if (result_stb !== 1'b1 || result_ch !== 1'b0 || result_timeout !== 1'b0 ||
        result_value < 4 || result_value > 6) begin
      failures++;
      $display("FAIL enable_drop_result: stb=%b ch=%b v=%0d to=%b want 1/0/4..6/0",
               result_stb, result_ch, result_value, result_timeout);
    end
    b = 0;
    while (busy && b < 40) begin @(negedge clk); b++; end
    checks++;
    if (busy !== 1'b0 || b != 9 || trig_out !== 2'b00 || cur_ch !== 1'b1) begin
      failures++;
      $display("FAIL enable_drop_idle: busy=%b after %0d trig=%b ch=%b want 0 after 9, 00, 1", busy, b, trig_out, cur_ch);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || trig_out !== 2'b00) begin
      failures++;
      $display("FAIL enable_drop_stays_idle: busy=%b trig=%b want 0/00", busy, trig_out);
    end
  endtask

  task automatic test_reset_mid;
    int len, stbs;
    enable = 1'b1;
    wait_trig_end(len);
    checks++;
    if (len != 4) begin
      failures++;
      $display("FAIL restart_trig_width: got %0d want 4", len);
    end
    repeat (2) @(negedge clk);
    echo_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    rd_sel = 1'b0;
    @(negedge clk);
    checks++;
    if (trig_out !== 2'b00 || busy !== 1'b0 || rd_flags !== 2'b00 || result_stb !== 1'b0 || cur_ch !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: trig=%b busy=%b flags=%b stb=%b ch=%b want 00/0/00/0/0",
               trig_out, busy, rd_flags, result_stb, cur_ch);
    end
    reset = 1'b0;
    echo_in[1] = 1'b0;
    stbs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_stb || busy) stbs++;
    end
    checks++;
    if (stbs != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d cycles with stb/busy want 0", stbs);
    end
  endtask

  initial begin
    test_reset;
    test_ch0_echo;
    test_timeout;
    test_saturate;
    test_stuck_echo;
    test_enable_drop;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
